multi_cycle_control: RTL and testbench

Multi-cycle control unit for the MIPS CPU: decodes the registered instruction fields and sequences each instruction through IF/ID/EXE/MEM/WB states. It sits directly upstream of the ALU and drives its 3-bit operation select and operand-source selects. It consumes the ALU's Zero and Sign flags to resolve branches. It also drives the PC, instruction register, register file and data-memory enables.

---
 rtl/multi_cycle_control_if.sv | 35 +++
 rtl/multi_cycle_control.sv | 205 ++++++++++++++++++++
 tb/tb_multi_cycle_control.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_cycle_control_if.sv
// Control-unit <-> datapath signal bundle: IR fields and ALU flags in, control selects and enables out.
// master is the control unit, slave is the datapath side.
interface multi_cycle_control_if;
    logic [5:0] Opcode;
    logic [5:0] Funct;
    logic       Zero;
    logic       Sign;
    logic [2:0] State;
    logic       PCWre;
    logic [1:0] PCSrc;
    logic       IRWre;
    logic [2:0] ALUOp;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ExtSel;
    logic       RegWre;
    logic [1:0] RegDst;
    logic       WrRegDSrc;
    logic       DBDataSrc;
    logic       mRD;
    logic       mWR;
    logic       Halted;

    modport master (
        input  Opcode, Funct, Zero, Sign,
        output State, PCWre, PCSrc, IRWre, ALUOp, ALUSrcA, ALUSrcB, ExtSel,
               RegWre, RegDst, WrRegDSrc, DBDataSrc, mRD, mWR, Halted
    );

    modport slave (
        output Opcode, Funct, Zero, Sign,
        input  State, PCWre, PCSrc, IRWre, ALUOp, ALUSrcA, ALUSrcB, ExtSel,
               RegWre, RegDst, WrRegDSrc, DBDataSrc, mRD, mWR, Halted
    );
endinterface

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS control FSM: decodes the IR opcode/funct and walks each instruction
// through IF/ID/EXE/MEM/WB, driving the ALU selects and the datapath write enables.
module multi_cycle_control (
    input  logic                  CLK,
    input  logic                  RST,
    multi_cycle_control_if.master bus
);
    typedef enum logic [2:0] {
        ST_IF    = 3'b000,
        ST_ID    = 3'b001,
        ST_EXE_M = 3'b010,
        ST_MEM   = 3'b011,
        ST_WB_L  = 3'b100,
        ST_EXE_B = 3'b101,
        ST_EXE_A = 3'b110,
        ST_WB_A  = 3'b111
    } state_t;

    typedef enum logic [3:0] {
        I_NOP, I_RALU, I_IMM, I_LW, I_SW, I_BR, I_J, I_JAL, I_JR, I_HALT
    } iclass_t;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLL  = 3'b010;
    localparam logic [2:0] ALU_OR   = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_CMPS = 3'b110;

    state_t     state_q, state_d;
    logic       halted_q, halted_d;
    iclass_t    iclass;
    logic [2:0] dec_aluop;
    logic       dec_srca;
    logic [1:0] dec_srcb;
    logic       dec_extsel;
    logic       br_taken;

    logic       pcwre, irwre, srca, extsel, regwre, wrsrc, dbsrc, mrd, mwr;
    logic [1:0] pcsrc, srcb, regdst;
    logic [2:0] aluop;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_IF;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    // Instruction decode; the IR is stable for the whole instruction, so this is valid in every state.
    always_comb begin
        iclass     = I_NOP;
        dec_aluop  = ALU_ADD;
        dec_srca   = 1'b0;
        dec_srcb   = 2'b00;
        dec_extsel = 1'b1;
        br_taken   = 1'b0;
        case (bus.Opcode)
            6'b000000: begin
                case (bus.Funct)
                    6'b100000: begin iclass = I_RALU; dec_aluop = ALU_ADD;  end
                    6'b100010: begin iclass = I_RALU; dec_aluop = ALU_SUB;  end
                    6'b100100: begin iclass = I_RALU; dec_aluop = ALU_AND;  end
                    6'b100101: begin iclass = I_RALU; dec_aluop = ALU_OR;   end
                    6'b101010: begin iclass = I_RALU; dec_aluop = ALU_CMPS; end
                    6'b000000: begin iclass = I_RALU; dec_aluop = ALU_SLL; dec_srca = 1'b1; end
                    6'b001000: iclass = I_JR;
                    default:   iclass = I_NOP;
                endcase
            end
            6'b001001: begin iclass = I_IMM; dec_aluop = ALU_ADD;  dec_srcb = 2'b01; end
            6'b001100: begin iclass = I_IMM; dec_aluop = ALU_AND;  dec_srcb = 2'b01; dec_extsel = 1'b0; end
            6'b001101: begin iclass = I_IMM; dec_aluop = ALU_OR;   dec_srcb = 2'b01; dec_extsel = 1'b0; end
            6'b001010: begin iclass = I_IMM; dec_aluop = ALU_CMPS; dec_srcb = 2'b01; end
            6'b100011: begin iclass = I_LW;  dec_aluop = ALU_ADD;  dec_srcb = 2'b01; end
            6'b101011: begin iclass = I_SW;  dec_aluop = ALU_ADD;  dec_srcb = 2'b01; end
            // Zero is inverted on this ALU: 1 means the difference was non-zero.
            6'b000100: begin iclass = I_BR; dec_aluop = ALU_SUB; br_taken = ~bus.Zero; end
            6'b000101: begin iclass = I_BR; dec_aluop = ALU_SUB; br_taken = bus.Zero;  end
            6'b000001: begin iclass = I_BR; dec_aluop = ALU_SUB; dec_srcb = 2'b10; br_taken = bus.Sign; end
            6'b000010: iclass = I_J;
            6'b000011: iclass = I_JAL;
            6'b111111: iclass = I_HALT;
            default:   iclass = I_NOP;
        endcase
    end

    // Enables are single-cycle strobes: the datapath acts on each one at the next CLK edge.
    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        pcwre    = 1'b0;
        pcsrc    = 2'b00;
        irwre    = 1'b0;
        aluop    = 3'b000;
        srca     = 1'b0;
        srcb     = 2'b00;
        extsel   = 1'b0;
        regwre   = 1'b0;
        regdst   = 2'b00;
        wrsrc    = 1'b0;
        dbsrc    = 1'b0;
        mrd      = 1'b0;
        mwr      = 1'b0;

        if (state_q != ST_IF && state_q != ST_ID) begin
            aluop  = dec_aluop;
            srca   = dec_srca;
            srcb   = dec_srcb;
            extsel = dec_extsel;
        end

        case (state_q)
            ST_IF: begin
                irwre   = 1'b1;
                state_d = ST_ID;
            end
            ST_ID: begin
                // With halted_q set this is the HALT state: no outputs, no exit until reset.
                if (!halted_q) begin
                    case (iclass)
                        I_RALU, I_IMM: state_d = ST_EXE_A;
                        I_LW, I_SW:    state_d = ST_EXE_M;
                        I_BR:          state_d = ST_EXE_B;
                        I_HALT:        halted_d = 1'b1;
                        I_J: begin
                            pcwre   = 1'b1;
                            pcsrc   = 2'b11;
                            state_d = ST_IF;
                        end
                        I_JAL: begin
                            pcwre   = 1'b1;
                            pcsrc   = 2'b11;
                            regwre  = 1'b1;
                            regdst  = 2'b00;
                            wrsrc   = 1'b0;
                            state_d = ST_IF;
                        end
                        I_JR: begin
                            pcwre   = 1'b1;
                            pcsrc   = 2'b10;
                            state_d = ST_IF;
                        end
                        default: begin
                            pcwre   = 1'b1;
                            state_d = ST_IF;
                        end
                    endcase
                end
            end
            ST_EXE_A: state_d = ST_WB_A;
            ST_WB_A: begin
                regwre  = 1'b1;
                pcwre   = 1'b1;
                regdst  = (iclass == I_RALU) ? 2'b10 : 2'b01;
                wrsrc   = 1'b1;
                state_d = ST_IF;
            end
            ST_EXE_M: state_d = ST_MEM;
            ST_MEM: begin
                if (iclass == I_LW) begin
                    mrd     = 1'b1;
                    state_d = ST_WB_L;
                end else begin
                    mwr     = 1'b1;
                    pcwre   = 1'b1;
                    state_d = ST_IF;
                end
            end
            ST_WB_L: begin
                regwre  = 1'b1;
                pcwre   = 1'b1;
                regdst  = 2'b01;
                wrsrc   = 1'b1;
                dbsrc   = 1'b1;
                state_d = ST_IF;
            end
            ST_EXE_B: begin
                pcwre   = 1'b1;
                pcsrc   = br_taken ? 2'b01 : 2'b00;
                state_d = ST_IF;
            end
            default: state_d = ST_IF;
        endcase
    end

    assign bus.State     = state_q;
    assign bus.Halted    = halted_q;
    assign bus.PCWre     = pcwre;
    assign bus.PCSrc     = pcsrc;
    assign bus.IRWre     = irwre;
    assign bus.ALUOp     = aluop;
    assign bus.ALUSrcA   = srca;
    assign bus.ALUSrcB   = srcb;
    assign bus.ExtSel    = extsel;
    assign bus.RegWre    = regwre;
    assign bus.RegDst    = regdst;
    assign bus.WrRegDSrc = wrsrc;
    assign bus.DBDataSrc = dbsrc;
    assign bus.mRD       = mrd;
    assign bus.mWR       = mwr;
endmodule

// File: tb/tb_multi_cycle_control.sv
// Bench for multi_cycle_control: per-instruction cycle traces built from the instruction
// paths and enable rules, compared cycle by cycle against the DUT outputs under a mask.
module tb_multi_cycle_control;
    typedef struct packed {
        logic [2:0] state;
        logic       halted;
        logic       irwre;
        logic       pcwre;
        logic [1:0] pcsrc;
        logic       regwre;
        logic [1:0] regdst;
        logic       wrregdsrc;
        logic       dbdatasrc;
        logic       mrd;
        logic       mwr;
        logic [2:0] aluop;
        logic       srca;
        logic [1:0] srcb;
        logic       extsel;
    } rec_t;

    localparam int W = $bits(rec_t);

    localparam logic [2:0] S_IF = 3'b000, S_ID = 3'b001, S_EA = 3'b110, S_EB = 3'b101;
    localparam logic [2:0] S_EM = 3'b010, S_MEM = 3'b011, S_WA = 3'b111, S_WL = 3'b100;

    // Directed table entries: {opcode, funct, zero, sign}
    localparam logic [13:0] DIR [20] = '{
        {6'b000000, 6'b100000, 2'b00}, {6'b100011, 6'b000000, 2'b00},
        {6'b101011, 6'b000000, 2'b00}, {6'b000100, 6'b000000, 2'b00},
        {6'b000100, 6'b000000, 2'b10}, {6'b000101, 6'b000000, 2'b10},
        {6'b000101, 6'b000000, 2'b00}, {6'b000001, 6'b000000, 2'b01},
        {6'b000001, 6'b000000, 2'b10}, {6'b000011, 6'b000000, 2'b00},
        {6'b000000, 6'b001000, 2'b00}, {6'b000010, 6'b000000, 2'b00},
        {6'b000000, 6'b000000, 2'b00}, {6'b001101, 6'b000000, 2'b00},
        {6'b001100, 6'b000000, 2'b00}, {6'b001010, 6'b000000, 2'b00},
        {6'b000000, 6'b101010, 2'b00}, {6'b000000, 6'b100010, 2'b00},
        {6'b010000, 6'b000000, 2'b00}, {6'b000000, 6'b111111, 2'b00}
    };

    logic CLK = 1'b0;
    logic RST = 1'b0;
    multi_cycle_control_if bus ();

    multi_cycle_control dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] msk_q[$];
    logic [W-1:0] obs_q[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic rec_t sample_obs();
        rec_t r;
        r.state     = bus.State;
        r.halted    = bus.Halted;
        r.irwre     = bus.IRWre;
        r.pcwre     = bus.PCWre;
        r.pcsrc     = bus.PCSrc;
        r.regwre    = bus.RegWre;
        r.regdst    = bus.RegDst;
        r.wrregdsrc = bus.WrRegDSrc;
        r.dbdatasrc = bus.DBDataSrc;
        r.mrd       = bus.mRD;
        r.mwr       = bus.mWR;
        r.aluop     = bus.ALUOp;
        r.srca      = bus.ALUSrcA;
        r.srcb      = bus.ALUSrcB;
        r.extsel    = bus.ExtSel;
        return r;
    endfunction

    function automatic rec_t enable_mask();
        rec_t m = '0;
        m.state = 3'b111; m.halted = 1'b1; m.irwre = 1'b1; m.pcwre = 1'b1;
        m.regwre = 1'b1; m.mrd = 1'b1; m.mwr = 1'b1;
        return m;
    endfunction

    // Reference: pick the instruction's state path, then place each enable by rule
    // (IR load first cycle, PC load last cycle, register write in the writeback cycle, ...).
    task automatic model_push(input logic [5:0] op, input logic [5:0] f, input logic z,
                              input logic s, output int n);
        logic [2:0] path[$];
        rec_t e, m;
        bit r_alu, imm, lw, sw, br, jmp, jal, jr, taken;
        logic [2:0] aop;
        logic sa, ext;
        logic [1:0] sb, tgt, rdst;
        int wr_idx;
        r_alu = (op == 6'd0) && (f inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b000000});
        jr    = (op == 6'd0) && (f == 6'b001000);
        imm   = op inside {6'b001001, 6'b001100, 6'b001101, 6'b001010};
        lw    = (op == 6'b100011);
        sw    = (op == 6'b101011);
        br    = op inside {6'b000100, 6'b000101, 6'b000001};
        jmp   = (op == 6'b000010);
        jal   = (op == 6'b000011);
        taken = (op == 6'b000100 && !z) || (op == 6'b000101 && z) || (op == 6'b000001 && s);
        aop = 3'b000; sa = 1'b0;
        if (op == 6'd0) begin
            case (f)
                6'b100010: aop = 3'b001;
                6'b100100: aop = 3'b100;
                6'b100101: aop = 3'b011;
                6'b101010: aop = 3'b110;
                6'b000000: begin aop = 3'b010; sa = 1'b1; end
                default:   aop = 3'b000;
            endcase
        end else if (br) aop = 3'b001;
        else if (op == 6'b001100) aop = 3'b100;
        else if (op == 6'b001101) aop = 3'b011;
        else if (op == 6'b001010) aop = 3'b110;
        sb   = (imm || lw || sw) ? 2'b01 : (op == 6'b000001) ? 2'b10 : 2'b00;
        ext  = !(op == 6'b001100 || op == 6'b001101);
        tgt  = (br && taken) ? 2'b01 : (jmp || jal) ? 2'b11 : jr ? 2'b10 : 2'b00;
        rdst = r_alu ? 2'b10 : jal ? 2'b00 : 2'b01;
        path = '{S_IF, S_ID};
        if (r_alu || imm) path = '{S_IF, S_ID, S_EA, S_WA};
        else if (lw)      path = '{S_IF, S_ID, S_EM, S_MEM, S_WL};
        else if (sw)      path = '{S_IF, S_ID, S_EM, S_MEM};
        else if (br)      path = '{S_IF, S_ID, S_EB};
        n = path.size();
        wr_idx = (r_alu || imm || lw) ? n - 1 : jal ? 1 : -1;
        for (int i = 0; i < n; i++) begin
            e = '0;
            m = enable_mask();
            e.state = path[i];
            e.irwre = (i == 0);
            if (i == n - 1) begin
                e.pcwre = 1'b1;
                e.pcsrc = tgt;
                m.pcsrc = 2'b11;
            end
            if (i == wr_idx) begin
                e.regwre    = 1'b1;
                e.regdst    = rdst;
                e.wrregdsrc = !jal;
                m.regdst    = 2'b11;
                m.wrregdsrc = 1'b1;
                if (!jal) begin
                    e.dbdatasrc = lw;
                    m.dbdatasrc = 1'b1;
                end
            end
            if (i == 3) begin
                e.mrd = lw;
                e.mwr = sw;
            end
            if (i == 2) begin
                e.aluop = aop; e.srca = sa; e.srcb = sb; e.extsel = ext;
                m.aluop = 3'b111; m.srca = 1'b1; m.srcb = 2'b11; m.extsel = 1'b1;
            end
            exp_q.push_back(e);
            msk_q.push_back(m);
        end
    endtask

    // Driver: present one instruction from IF and capture one record per cycle.
    task automatic exec_instr(input logic [5:0] op, input logic [5:0] f, input logic z,
                              input logic s, input int n);
        for (int i = 0; i < n; i++) begin
            bus.Opcode = op;
            bus.Funct  = f;
            bus.Zero   = z;
            bus.Sign   = s;
            #1;
            obs_q.push_back(sample_obs());
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        rec_t exp_r;
        bus.Opcode = 6'd0; bus.Funct = 6'd0; bus.Zero = 1'b0; bus.Sign = 1'b0;
        RST = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        exp_r = '0;
        exp_r.irwre = 1'b1;
        n_checks++;
        if (sample_obs() !== exp_r) begin
            n_fail++;
            $display("FAIL reset_state got=%h exp=%h", sample_obs(), exp_r);
        end
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_directed();
        logic [13:0] v;
        int n;
        logic [W-1:0] o, e, m;
        for (int k = 0; k < 20; k++) begin
            v = DIR[k];
            model_push(v[13:8], v[7:2], v[1], v[0], n);
            exec_instr(v[13:8], v[7:2], v[1], v[0], n);
            for (int c = 0; c < n; c++) begin
                o = obs_q.pop_front(); e = exp_q.pop_front(); m = msk_q.pop_front();
                n_checks++;
                if ((o & m) !== (e & m)) begin
                    n_fail++;
                    $display("FAIL directed op=%b f=%b z=%b s=%b cyc=%0d got=%h exp=%h mask=%h",
                             v[13:8], v[7:2], v[1], v[0], c, o, e, m);
                end
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] op, f;
        logic z, s;
        int n;
        logic [W-1:0] o, e, m;
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 3))
                0: op = 6'd0;
                1: op = $urandom_range(0, 62);
                default: begin
                    case ($urandom_range(0, 11))
                        0: op = 6'b001001;  1: op = 6'b001100;  2: op = 6'b001101;
                        3: op = 6'b001010;  4: op = 6'b100011;  5: op = 6'b101011;
                        6: op = 6'b000100;  7: op = 6'b000101;  8: op = 6'b000001;
                        9: op = 6'b000010;  10: op = 6'b000011; default: op = 6'd0;
                    endcase
                end
            endcase
            f = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 63)) : 6'b100000;
            z = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            model_push(op, f, z, s, n);
            exec_instr(op, f, z, s, n);
            for (int c = 0; c < n; c++) begin
                o = obs_q.pop_front(); e = exp_q.pop_front(); m = msk_q.pop_front();
                n_checks++;
                if ((o & m) !== (e & m)) begin
                    n_fail++;
                    $display("FAIL random op=%b f=%b z=%b s=%b cyc=%0d got=%h exp=%h mask=%h",
                             op, f, z, s, c, o, e, m);
                end
            end
        end
    endtask

    task automatic test_halt();
        rec_t o, e, m;
        bus.Opcode = 6'b111111; bus.Funct = 6'd0; bus.Zero = 1'b0; bus.Sign = 1'b0;
        m = enable_mask();
        for (int c = 0; c < 14; c++) begin
            #1;
            o = sample_obs();
            e = '0;
            e.state  = (c == 0) ? S_IF : S_ID;
            e.irwre  = (c == 0);
            e.halted = (c >= 2);
            n_checks++;
            if ((o & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL halt_hold cyc=%0d got=%h exp=%h", c, o, e);
            end
            @(negedge CLK);
        end
        RST = 1'b0;
        #1;
        n_checks++;
        if (bus.State !== S_IF || bus.Halted !== 1'b0 || bus.IRWre !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_reset got state=%b halted=%b irwre=%b exp 000/0/1",
                     bus.State, bus.Halted, bus.IRWre);
        end
        @(negedge CLK);
        RST = 1'b1;
    endtask

    task automatic test_reset_mid();
        int n;
        logic [W-1:0] o, e, m;
        bus.Opcode = 6'b101011; bus.Funct = 6'd0; bus.Zero = 1'b0; bus.Sign = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        n_checks++;
        if (bus.State !== S_MEM || bus.mWR !== 1'b1) begin
            n_fail++;
            $display("FAIL sw_mem_before_reset got state=%b mwr=%b exp 011/1", bus.State, bus.mWR);
        end
        #1 RST = 1'b0;
        #1;
        n_checks++;
        if (bus.mWR !== 1'b0 || bus.State !== S_IF || bus.IRWre !== 1'b1 || bus.PCWre !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got mwr=%b state=%b irwre=%b pcwre=%b exp 0/000/1/0",
                     bus.mWR, bus.State, bus.IRWre, bus.PCWre);
        end
        @(negedge CLK);
        #1;
        n_checks++;
        if (bus.State !== S_IF || bus.mWR !== 1'b0 || bus.RegWre !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_held got state=%b mwr=%b regwre=%b exp 000/0/0",
                     bus.State, bus.mWR, bus.RegWre);
        end
        @(negedge CLK);
        RST = 1'b1;
        model_push(6'b000000, 6'b100000, 1'b0, 1'b0, n);
        exec_instr(6'b000000, 6'b100000, 1'b0, 1'b0, n);
        for (int c = 0; c < n; c++) begin
            o = obs_q.pop_front(); e = exp_q.pop_front(); m = msk_q.pop_front();
            n_checks++;
            if ((o & m) !== (e & m)) begin
                n_fail++;
                $display("FAIL resume_add cyc=%0d got=%h exp=%h mask=%h", c, o, e, m);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_halt();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
